// File: rtl/sync_updown_mod_counter.sv
// sync_updown_mod_counter
// Fully synchronous up/down counter over the range 0..MAX_COUNT. It supports
// enable, direction, parallel load with clamping, and a synchronous clear.
// It can either wrap or saturate at the range ends. tc is combinational;
// wrap and ovf are registered.
module sync_updown_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // All range-end comparisons are made at the counter width.
    localparam logic [WIDTH-1:0] MAX_Q = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);
    localparam bit               SAT   = (SATURATE != 0);

    logic             at_max;
    logic             at_zero;
    logic             event_hit;
    logic [WIDTH-1:0] q_next;

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);

    // The terminal count depends only on en, up and q. clr and load are deliberately excluded.
    assign tc = en & ((up & at_max) | (~up & at_zero));

    // A range-end event is a terminal count that is not pre-empted by clr or load.
    assign event_hit = tc & ~clr & ~load;

    // Next count, evaluated in priority order clr > load > en. Otherwise the count holds.
    always_comb begin
        // NOTE: default first so every path assigns q_next and no latch is inferred.
        q_next = q;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (en) begin
            if (up) begin
                q_next = at_max ? (SAT ? q : '0) : q + ONE_Q;
            end else begin
                q_next = at_zero ? (SAT ? q : MAX_Q) : q - ONE_Q;
            end
        end
    end

    // State registers. rst overrides everything. A range-end event takes priority over ovf_clr.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= event_hit;
            if (event_hit) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// tb_sync_updown_mod_counter
// Directed scoreboard bench. Two counters share the same stimulus:
//   dut_a: MAX_COUNT=9, wrapping.
//   dut_b: MAX_COUNT=15, saturating.
// The driver pushes hand-computed expectations. The monitor pops and compares
// one expectation around each clock edge.
module tb_sync_updown_mod_counter;

    typedef struct {
        string name;
        int    sel;   // 0 = dut_a, 1 = dut_b, 2 = both
        int    eq;    // q after the edge
        bit    etc;   // tc just before the edge
        bit    ew;    // wrap after the edge
        bit    eo;    // ovf after the edge
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       ovf_clr = 1'b0;

    logic [3:0] q_a, q_b;
    logic       tc_a, tc_b, wrap_a, wrap_b, ovf_a, ovf_b;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    sync_updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
        .q(q_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    sync_updown_mod_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
        .q(q_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then optionally queue the expectation.
    task automatic step(input string name, input int sel, input bit push,
                        input bit r, input bit c, input bit e, input bit u,
                        input bit l, input logic [3:0] lv, input bit oc,
                        input int eq, input bit etc, input bit ew, input bit eo);
        exp_t it;
        @(negedge clk);
        rst = r; clr = c; en = e; up = u; load = l; load_val = lv; ovf_clr = oc;
        if (push) begin
            it.name = name; it.sel = sel; it.eq = eq;
            it.etc = etc; it.ew = ew; it.eo = eo;
            sb.push_back(it);
        end
    endtask

    // Monitor: sample tc just before the rising edge, then the registered outputs just after it.
    initial begin
        exp_t it;
        logic sa, sb_tc;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                sa = tc_a;
                sb_tc = tc_b;
                @(posedge clk);
                #1;
                it = sb.pop_front();
                if (it.sel != 1) begin
                    check({it.name, " A q"},    int'(q_a),    it.eq);
                    check({it.name, " A tc"},   int'(sa),     int'(it.etc));
                    check({it.name, " A wrap"}, int'(wrap_a), int'(it.ew));
                    check({it.name, " A ovf"},  int'(ovf_a),  int'(it.eo));
                end
                if (it.sel != 0) begin
                    check({it.name, " B q"},    int'(q_b),    it.eq);
                    check({it.name, " B tc"},   int'(sb_tc),  int'(it.etc));
                    check({it.name, " B wrap"}, int'(wrap_b), int'(it.ew));
                    check({it.name, " B ovf"},  int'(ovf_b),  int'(it.eo));
                end
            end
        end
    end

    // Driver: directed vectors, each with a hand-computed expectation.
    initial begin
        // Initial reset cycles. q is unknown before these edges, so they are not checked.
        step("init", 2, 0, 1, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 0);
        step("init", 2, 0, 1, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 0);

        // Reset overrides en and load.
        step("reset", 2, 1, 1, 0, 1, 1, 1, 4'd9, 0, 0, 0, 0, 0);

        // Wrap up on dut_a: 1..9, then 0 with a wrap pulse and sticky ovf.
        for (int i = 0; i < 9; i++)
            step("count_up", 0, 1, 0, 0, 1, 1, 0, 4'd0, 0, i + 1, 0, 0, 0);
        step("wrap_up", 0, 1, 0, 0, 1, 1, 0, 4'd0, 0, 0, 1, 1, 1);
        step("after_wrap", 0, 1, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 1);

        // Wrap down on dut_a, then clear ovf when no event occurs.
        step("load0", 0, 1, 0, 0, 0, 1, 1, 4'd0, 0, 0, 0, 0, 1);
        step("wrap_down", 0, 1, 0, 0, 1, 0, 0, 4'd0, 0, 9, 1, 1, 1);
        step("ovf_clr", 0, 1, 0, 0, 0, 0, 0, 4'd0, 1, 9, 0, 0, 0);

        // Saturate on dut_b: load 14, then count up three times.
        step("sat_load", 1, 1, 0, 0, 0, 1, 1, 4'd14, 0, 14, 0, 0, 0);
        step("sat_1", 1, 1, 0, 0, 1, 1, 0, 4'd0, 0, 15, 0, 0, 0);
        step("sat_2", 1, 1, 0, 0, 1, 1, 0, 4'd0, 0, 15, 1, 1, 1);
        step("sat_3", 1, 1, 0, 0, 1, 1, 0, 4'd0, 0, 15, 1, 1, 1);

        // Priority and clamp on dut_a. The previous block left dut_a at q=2 with ovf=1.
        step("pre_clr", 0, 1, 0, 0, 0, 1, 0, 4'd0, 1, 2, 0, 0, 0);
        step("clamp", 0, 1, 0, 0, 1, 1, 1, 4'd12, 0, 9, 0, 0, 0);
        step("clr_over_load", 0, 1, 0, 1, 1, 1, 1, 4'd5, 0, 0, 1, 0, 0);
        step("load9", 0, 1, 0, 0, 0, 1, 1, 4'd9, 0, 9, 0, 0, 0);
        step("event_vs_ovf_clr", 0, 1, 0, 0, 1, 1, 0, 4'd0, 1, 0, 1, 1, 1);

        // Hold on dut_a at q=5 while up toggles.
        step("load5", 0, 1, 0, 0, 0, 1, 1, 4'd5, 0, 5, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            step("hold", 0, 1, 0, 0, 0, i[0], 0, 4'd0, 0, 5, 0, 0, 1);

        // Reset mid-count, counting resumes, then the direction changes mid-count.
        step("mid_rst", 0, 1, 1, 0, 1, 1, 0, 4'd0, 0, 0, 0, 0, 0);
        step("resume", 0, 1, 0, 0, 1, 1, 0, 4'd0, 0, 1, 0, 0, 0);
        step("dir_down", 0, 1, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0, 0, 0);
        step("down_wrap", 0, 1, 0, 0, 1, 0, 0, 4'd0, 0, 9, 1, 1, 1);
        step("idle", 2, 0, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 0);

        // Let the monitor drain the queue, with a bound on how long that may take.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
